// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Key code layout is {row[1:0], col[1:0]}.
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    PRESSED,
    DEB_REL
  } state_t;

  // Lowest row wins when several rows are pulled low together
  function automatic logic [1:0] lowest_zero(
    input logic [ROWS-1:0] v
  );
    logic [1:0] idx;
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Key event bundle from the scanner to display/command logic.
// master drives the event, slave consumes it.
interface keypad_matrix_scanner_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;

  modport master (
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    input key_code,
    input key_valid,
    input key_held
  );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows.
// Resets to all-ones so an idle pad reads as no key.
module keypad_sync
  import keypad_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] d,
  output logic [ROWS-1:0] q
);

  logic [ROWS-1:0] meta;
  logic [ROWS-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      sync <= '1;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: column strobe, row sample, debounce,
// and key event generation.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  keypad_matrix_scanner_if.master kp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0] STEP_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);

  logic [ROWS-1:0] row_s;

  state_t           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [DW-1:0]    deb_q, deb_d;
  logic [1:0]       col_q, col_d;
  logic [ROWS-1:0]  pat_q, pat_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;

  keypad_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_in),
    .q     (row_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      step_q  <= '0;
      deb_q   <= '0;
      col_q   <= '0;
      pat_q   <= '1;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      deb_q   <= deb_d;
      col_q   <= col_d;
      pat_q   <= pat_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    deb_d   = deb_q;
    col_d   = col_q;
    pat_d   = pat_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;

    unique case (state_q)
      SCAN: begin
        // Rows are only trusted at step end, after the strobe settles
        if (step_q == STEP_LAST) begin
          step_d = '0;
          if (row_s == '1) begin
            col_d = col_q + 2'd1;
          end else begin
            pat_d   = row_s;
            deb_d   = '0;
            state_d = DEB_PRESS;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      DEB_PRESS: begin
        if (row_s != pat_q) begin
          state_d = SCAN;
          step_d  = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          code_d  = {lowest_zero(pat_q), col_q};
          valid_d = 1'b1;
          held_d  = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      PRESSED: begin
        if (row_s == '1) begin
          state_d = DEB_REL;
          deb_d   = '0;
        end
      end

      DEB_REL: begin
        if (row_s != '1) begin
          state_d = PRESSED;
        end else if (deb_q == DEB_LAST) begin
          state_d = SCAN;
          step_d  = '0;
          held_d  = 1'b0;
          col_d   = col_q + 2'd1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      default: begin
        state_d = SCAN;
        step_d  = '0;
      end
    endcase
  end

  assign col_out      = ~(COLS'(1) << col_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner with a behavioural 4x4 membrane
// model and a queue of expected key events.
module tb_keypad_matrix_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [15:0] keys;
  logic [3:0]  force_low;

  keypad_matrix_scanner_if kp ();

  keypad_matrix_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .row_in  (row_in),
    .col_out (col_out),
    .kp      (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed key (r,c) pulls row r low while column c is strobed
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_in[r] = ~(force_low[r] |
        (|(keys[r*4 +: 4] & ~col_out)));
    end
  end

  int pass_cnt = 0;
  int total    = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_e;
  logic       prev_v = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      check("valid_one_cycle", {31'd0, prev_v}, 0);
      check("valid_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("key_code_on_valid", {28'd0, kp.key_code}, {28'd0, mon_e});
      end
    end
    prev_v <= kp.key_valid;
  end

  task automatic wait_held(input logic v, input int max,
                           input string name);
    int n;
    n = 0;
    while (kp.key_held !== v && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, kp.key_held}, {31'd0, v});
  endtask

  typedef struct {
    int         row;
    int         col;
    logic [3:0] exp_code;
    logic [3:0] exp_frozen;
    logic [3:0] exp_after;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [3:0] e;
    int cnt;

    tbl[0] = '{2, 1, 4'h9, 4'b1101, 4'b1011};
    tbl[1] = '{0, 0, 4'h0, 4'b1110, 4'b1101};
    tbl[2] = '{3, 3, 4'hF, 4'b0111, 4'b1110};
    tbl[3] = '{1, 2, 4'h6, 4'b1011, 4'b0111};

    rst_n = 1'b0;
    keys = '0;
    force_low = '0;
    repeat (3) @(negedge clk);
    check("rst_col", {28'd0, col_out}, 32'hE);
    check("rst_code", {28'd0, kp.key_code}, 0);
    check("rst_valid", {31'd0, kp.key_valid}, 0);
    check("rst_held", {31'd0, kp.key_held}, 0);
    rst_n = 1'b1;

    // Idle rotation: 4 clocks per column
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col", {28'd0, col_out}, {28'd0, e});
    end
    check("idle_code", {28'd0, kp.key_code}, 0);

    foreach (tbl[i]) begin
      keys = '0;
      keys[tbl[i].row*4 + tbl[i].col] = 1'b1;
      exp_q.push_back(tbl[i].exp_code);
      wait_held(1'b1, 100, "tbl_press_held");
      repeat (10) @(negedge clk);
      check("tbl_col_frozen", {28'd0, col_out}, {28'd0, tbl[i].exp_frozen});
      check("tbl_code", {28'd0, kp.key_code}, {28'd0, tbl[i].exp_code});
      keys = '0;
      wait_held(1'b0, 100, "tbl_release");
      check("tbl_col_after", {28'd0, col_out}, {28'd0, tbl[i].exp_after});
      check("tbl_code_kept", {28'd0, kp.key_code}, {28'd0, tbl[i].exp_code});
      repeat (3) @(negedge clk);
    end

    // Bouncing contact on row2/col1
    keys = '0;
    exp_q.push_back(4'h9);
    for (int i = 0; i < 7; i++) begin
      keys[9] = ~keys[9];
      repeat (3) @(negedge clk);
    end
    check("bounce_no_early", {31'd0, kp.key_held}, 0);
    wait_held(1'b1, 100, "bounce_held");
    check("bounce_code", {28'd0, kp.key_code}, 32'h9);
    keys = '0;
    wait_held(1'b0, 100, "bounce_release");

    // Two keys in column 0: row1 wins, partial release ignored
    keys = '0;
    keys[12] = 1'b1;
    keys[4]  = 1'b1;
    exp_q.push_back(4'h4);
    wait_held(1'b1, 100, "multi_held");
    check("multi_code", {28'd0, kp.key_code}, 32'h4);
    keys[4] = 1'b0;
    repeat (30) @(negedge clk);
    check("multi_partial_held", {31'd0, kp.key_held}, 1);
    check("multi_partial_code", {28'd0, kp.key_code}, 32'h4);
    keys = '0;
    wait_held(1'b0, 100, "multi_release");

    // Short glitch on row0 while column 3 is strobed
    cnt = 0;
    while (col_out !== 4'b0111 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("glitch_reach_col3", {28'd0, col_out}, 32'h7);
    force_low = 4'b0001;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt++;
    end
    force_low = '0;
    while (col_out === 4'b0111 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("glitch_col3_extended", {31'd0, cnt > 4}, 1);
    check("glitch_wrap", {28'd0, col_out}, 32'hE);
    check("glitch_no_held", {31'd0, kp.key_held}, 0);

    // Reset while 0xF is held, then re-detect
    keys = '0;
    keys[15] = 1'b1;
    exp_q.push_back(4'hF);
    wait_held(1'b1, 100, "rstp_held");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstp_col", {28'd0, col_out}, 32'hE);
    check("rstp_code", {28'd0, kp.key_code}, 0);
    check("rstp_valid", {31'd0, kp.key_valid}, 0);
    check("rstp_held", {31'd0, kp.key_held}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'hF);
    wait_held(1'b1, 100, "rstp_redetect");
    check("rstp_code_again", {28'd0, kp.key_code}, 32'hF);
    keys = '0;
    wait_held(1'b0, 100, "rstp_release");

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
